// File: rtl/ifetch_if.sv
// ifetch_if: ICache request/return, backend redirect and decoder handshake of the fetch unit
interface ifetch_if;
  logic        fetch_able;
  logic [31:0] fetch_pc;
  logic        ic_hit;
  logic [31:0] ic_ins;
  logic [31:0] ic_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        issue_ready;
  modport master (
    output fetch_able, fetch_pc, ins_valid, ins_out, ins_pc, pred_taken, pred_pc,
    input  ic_hit, ic_ins, ic_pc, flush, flush_pc, issue_ready
  );
  modport slave (
    input  fetch_able, fetch_pc, ins_valid, ins_out, ins_pc, pred_taken, pred_pc,
    output ic_hit, ic_ins, ic_pc, flush, flush_pc, issue_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: static-predicting PC generator feeding an instruction FIFO to the decoder
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          QUEUE_AW    = 2
) (
  input logic      clk_in,
  input logic      rst_in,
  input logic      rdy_in,
  ifetch_if.master bus
);
  typedef enum logic {FETCH, JALR_WAIT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, next_pc, j_imm, b_imm;
  logic [QUEUE_AW:0] count;
  logic [QUEUE_AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] ins_q [QUEUE_DEPTH];
  logic [31:0] pc_q [QUEUE_DEPTH];
  logic [31:0] pred_q [QUEUE_DEPTH];
  logic taken_q [QUEUE_DEPTH];
  logic jal, br_back, jalr, taken, push, pop, valid;
  always_comb begin
    jal = bus.ic_ins[6:0] == 7'b1101111;
    br_back = bus.ic_ins[6:0] == 7'b1100011 && bus.ic_ins[31];
    jalr = bus.ic_ins[6:0] == 7'b1100111;
    j_imm = {{11{bus.ic_ins[31]}}, bus.ic_ins[31], bus.ic_ins[19:12], bus.ic_ins[20], bus.ic_ins[30:21], 1'b0};
    b_imm = {{19{bus.ic_ins[31]}}, bus.ic_ins[31], bus.ic_ins[7], bus.ic_ins[30:25], bus.ic_ins[11:8], 1'b0};
    taken = jal | br_back;
    next_pc = pc + (jal ? j_imm : br_back ? b_imm : 32'd4);
    valid = count != '0;
    // count never exceeds QUEUE_DEPTH, so its MSB alone marks a full queue
    bus.fetch_able = rdy_in & ~rst_in & ~bus.flush & (state == FETCH) & ~count[QUEUE_AW];
    push = bus.fetch_able & bus.ic_hit & (bus.ic_pc == pc);
    pop = valid & bus.issue_ready;
    state_nx = bus.flush ? FETCH : (push && jalr) ? JALR_WAIT : state;
    bus.fetch_pc = pc;
    bus.ins_valid = valid;
    bus.ins_out = valid ? ins_q[rd_ptr] : '0;
    bus.ins_pc = valid ? pc_q[rd_ptr] : '0;
    bus.pred_pc = valid ? pred_q[rd_ptr] : '0;
    bus.pred_taken = valid & taken_q[rd_ptr];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= FETCH;
      pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (rdy_in) begin
      state <= state_nx;
      if (bus.flush) begin
        pc <= bus.flush_pc;
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) pc <= next_pc;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{QUEUE_AW{1'b0}}, push} - {{QUEUE_AW{1'b0}}, pop};
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) begin
      ins_q[wr_ptr] <= bus.ic_ins;
      pc_q[wr_ptr] <= pc;
      pred_q[wr_ptr] <= next_pc;
      taken_q[wr_ptr] <= taken;
    end
  end
endmodule
